axi_full_mem_slave: RTL and testbench
=====================================

# axi_full_mem_slave

Parametrised AXI4 memory slave with independent read and write channels, FIXED/INCR/WRAP bursts, byte strobes and protocol-error responses. It is the on-chip memory target the cache's AXI master fetches lines from and writes dirty lines back to. Storage is an internal word array with no DPI dependence, so benches can preload and inspect it directly. It is the successor to the read-only INCR slave.

## Interface
- DATA_W, 64, data bus width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- MEM_WORDS, 1024, depth of the storage array in DATA_W words.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- araddr  in  ADDR_W; arlen  in  8; arsize  in  3; arburst  in  2; arvalid  in  1; arready  out  1.
- rdata  out  DATA_W; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1.
- awaddr  in  ADDR_W; awlen  in  8; awsize  in  3; awburst  in  2; awvalid  in  1; awready  out  1.
- wdata  in  DATA_W; wstrb  in  DATA_W/8; wlast  in  1; wvalid  in  1; wready  out  1.
- bresp  out  2; bvalid  out  1; bready  in  1.

## Operation
- Word index: addr >> log2(DATA_W/8). Sub-word address bits are ignored for storage, but the byte address drives address stepping.
- Read FSM has two states:
  - R_IDLE: arready=1. An AR handshake latches addr, len, size and burst, clears the beat counter and moves to R_BURST.
  - R_BURST: rvalid=1, and rdata is the word at the current address. rlast=1 when beat counter == latched len. Each R handshake advances the address and counter. A handshake with rlast=1 returns to R_IDLE.
- Write FSM has three states:
  - W_IDLE: awready=1. An AW handshake latches the burst fields and moves to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb. The beat with counter == len moves to W_RESP.
  - W_RESP: bvalid=1. A B handshake returns to W_IDLE.
- Address step per beat, with step = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): address + step.
  - WRAP (10): address + step, wrapping within the aligned (len+1)*step region.
- Errors: the whole burst returns SLVERR (2'b10) if any of these holds:
  - burst == 2'b11;
  - size > log2(DATA_W/8);
  - WRAP with len not in {1,3,7,15};
  - any beat whose word index >= MEM_WORDS.
- Per-beat error behaviour:
  - Read: an erroring beat returns rdata=0 with rresp=SLVERR; other beats return OKAY.
  - Write: an erroring beat writes nothing. bresp is SLVERR if any beat erred, otherwise OKAY.
- wlast is checked against the internal count. A mismatch on any beat (early or missing) makes bresp SLVERR. The burst length is always governed by the latched len, never by wlast.
- The read and write channels are fully independent and may be active in the same cycle.

## Timing
- Reset values:
  - arready=1, awready=1.
  - rvalid=0, wready=0, bvalid=0.
  - rlast=0, rresp=00, bresp=00, rdata=0.
  - Both FSMs are idle. Memory contents are not reset.
- Read latency: an AR handshake in cycle T gives rvalid=1 in T+1. With rready held high, one beat is transferred per cycle, so len+1 beats complete in T+1..T+1+len. arready is 1 again in the cycle after the rlast handshake.
- Write latency: an AW handshake in T gives wready=1 in T+1. bvalid=1 in the cycle after the last W handshake. awready is 1 in the cycle after the B handshake.
- rdata, rresp and rlast stay stable while rvalid=1 and rready=0. bresp stays stable while bvalid=1.
- Same-cycle read and write to the same word: the read returns the old data; the new data is visible from the next cycle.
- rst asserted mid-burst aborts both FSMs to idle at that edge. Partially written beats stay in memory, and no B response is issued.

## Test plan
- Preload words 0..7 with 0x1000+i; INCR read at araddr=0x0 with len=3, size=3, rready high -> rdata 0x1000..0x1003 on consecutive cycles, rlast on beat 4 only, rresp=00, arready high one cycle later.
- WRAP read at 0x18 with len=3, size=3 -> words 3,0,1,2 returned.
- INCR write at 0x40 with len=1, wdata 0xAAAA_BBBB_CCCC_DDDD then 0x1111..., second beat wstrb=0x0F -> word 8 fully written, word 9 low 4 bytes only, bresp=00.
- FIXED read with len=2 while rready toggles 1,0,1,0,1 -> the same word is returned 3 times, outputs are stable during stalls, and the total is 3 beats.
- Write with burst=11, or to awaddr=MEM_WORDS*8 -> memory unchanged and bresp=10. A read with size=4 on DATA_W=64 -> all beats rdata=0, rresp=10.
- rst raised during beat 2 of an 8-beat read -> rvalid=0 and arready=1 after that edge; a new AR is accepted correctly.

Source files
------------

// File: rtl/axi_full_mem_slave_if.sv
// AXI4 bus bundle for the on-chip memory slave: the five channels AR, R, AW, W and B.
interface axi_full_mem_slave_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready,
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

  modport master (
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready,
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_full_mem_slave.sv
// AXI4 memory slave with independent read and write engines, FIXED/INCR/WRAP bursts,
// byte strobes and SLVERR reporting for illegal bursts or out-of-range beats.
//
// state   | meaning
// --------+-----------------------------------------------------------
// R_IDLE  | arready high, waiting for an AR handshake
// R_BURST | rvalid high, presenting the current beat until rlast is taken
// W_IDLE  | awready high, waiting for an AW handshake
// W_DATA  | wready high, writing one beat per W handshake
// W_RESP  | bvalid high, holding bresp until the B handshake
module axi_full_mem_slave #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_full_mem_slave_if.slave  s_axi
);
  localparam int         STRB_W      = DATA_W / 8;
  localparam int         LOG2B       = $clog2(STRB_W);
  localparam int         IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [2:0] MAX_SIZE    = 3'(LOG2B);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic       {R_IDLE, R_BURST}         r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;

  logic [DATA_W-1:0] r_mem [MEM_WORDS];

  // Burst-level legality: reserved burst type, oversize beat, or a WRAP length that is not a power of two.
  function automatic logic f_burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || (size > MAX_SIZE) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  function automatic logic f_addr_err(input logic [ADDR_W-1:0] addr);
    return (addr >> LOG2B) >= ADDR_W'(MEM_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> LOG2B);
  endfunction

  // Byte address of the following beat; WRAP keeps the upper bits of the aligned window fixed.
  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [7:0] len,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] incr;
    step      = ADDR_W'(1) << size;
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr      = addr + step;
    case (burst)
      BURST_FIXED: f_next_addr = addr;
      BURST_WRAP:  f_next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
      default:     f_next_addr = incr;
    endcase
  endfunction

  // ---------------- read channel ----------------
  r_state_t          r_rstate, w_rnext;
  logic [ADDR_W-1:0] r_ar_addr;
  logic [7:0]        r_ar_len;
  logic [2:0]        r_ar_size;
  logic [1:0]        r_ar_burst;
  logic              r_ar_berr;
  logic [7:0]        r_rbeat;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_rresp;
  logic              w_arready, w_rvalid, w_rlast;
  logic              w_ar_hs, w_r_hs;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_berr, w_rd_err;
  logic [DATA_W-1:0] w_rd_word;

  assign w_rlast   = (r_rstate == R_BURST) && (r_rbeat == r_ar_len);
  assign w_ar_hs   = s_axi.arvalid && w_arready;
  assign w_r_hs    = w_rvalid && s_axi.rready;
  // The beat loaded into the output register is either the first beat of a new burst or the next one.
  assign w_rd_addr = w_ar_hs ? s_axi.araddr
                             : f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
  assign w_rd_berr = w_ar_hs ? f_burst_err(s_axi.arlen, s_axi.arsize, s_axi.arburst) : r_ar_berr;
  assign w_rd_err  = w_rd_berr || f_addr_err(w_rd_addr);
  assign w_rd_word = r_mem[f_idx(w_rd_addr)];

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;
  end

  // Read FSM next state and handshake outputs
  always_comb begin
    w_rnext   = r_rstate;
    w_arready = 1'b0;
    w_rvalid  = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        w_arready = 1'b1;
        if (s_axi.arvalid) w_rnext = R_BURST;
      end
      R_BURST: begin
        w_rvalid = 1'b1;
        if (s_axi.rready && w_rlast) w_rnext = R_IDLE;
      end
      default: w_rnext = R_IDLE;
    endcase
  end

  // Read datapath: rdata/rresp are registered so they hold through stalls even if a write hits the word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_addr  <= '0;
      r_ar_len   <= '0;
      r_ar_size  <= '0;
      r_ar_burst <= '0;
      r_ar_berr  <= 1'b0;
      r_rbeat    <= '0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_ar_addr  <= s_axi.araddr;
      r_ar_len   <= s_axi.arlen;
      r_ar_size  <= s_axi.arsize;
      r_ar_burst <= s_axi.arburst;
      r_ar_berr  <= w_rd_berr;
      r_rbeat    <= '0;
      r_rdata    <= w_rd_err ? '0 : w_rd_word;
      r_rresp    <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (w_r_hs && !w_rlast) begin
      r_ar_addr  <= w_rd_addr;
      r_rbeat    <= r_rbeat + 8'd1;
      r_rdata    <= w_rd_err ? '0 : w_rd_word;
      r_rresp    <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = w_rvalid;
  assign s_axi.rlast   = w_rlast;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  // ---------------- write channel ----------------
  w_state_t          r_wstate, w_wnext;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [7:0]        r_aw_len;
  logic [2:0]        r_aw_size;
  logic [1:0]        r_aw_burst;
  logic              r_aw_berr;
  logic [7:0]        r_wbeat;
  logic              r_werr;
  logic [1:0]        r_bresp;
  logic              w_awready, w_wready, w_bvalid;
  logic              w_aw_hs, w_w_hs;
  logic              w_wlast_exp, w_wbeat_err, w_wlast_err, w_werr_acc;
  logic [IDX_W-1:0]  w_widx;

  assign w_aw_hs     = s_axi.awvalid && w_awready;
  assign w_w_hs      = s_axi.wvalid && w_wready;
  assign w_wlast_exp = (r_wbeat == r_aw_len);
  assign w_wbeat_err = r_aw_berr || f_addr_err(r_aw_addr);
  // wlast only feeds the response; the beat count alone ends the burst.
  assign w_wlast_err = (s_axi.wlast != w_wlast_exp);
  assign w_werr_acc  = r_werr || w_wbeat_err || w_wlast_err;
  assign w_widx      = f_idx(r_aw_addr);

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    w_wnext   = r_wstate;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bvalid  = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        w_awready = 1'b1;
        if (s_axi.awvalid) w_wnext = W_DATA;
      end
      W_DATA: begin
        w_wready = 1'b1;
        if (s_axi.wvalid && w_wlast_exp) w_wnext = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi.bready) w_wnext = W_IDLE;
      end
      default: w_wnext = W_IDLE;
    endcase
  end

  // Write datapath: latch the burst, step the address and accumulate any beat error into bresp
  always_ff @(posedge clk) begin
    if (rst) begin
      r_aw_addr  <= '0;
      r_aw_len   <= '0;
      r_aw_size  <= '0;
      r_aw_burst <= '0;
      r_aw_berr  <= 1'b0;
      r_wbeat    <= '0;
      r_werr     <= 1'b0;
      r_bresp    <= RESP_OKAY;
    end else if (w_aw_hs) begin
      r_aw_addr  <= s_axi.awaddr;
      r_aw_len   <= s_axi.awlen;
      r_aw_size  <= s_axi.awsize;
      r_aw_burst <= s_axi.awburst;
      r_aw_berr  <= f_burst_err(s_axi.awlen, s_axi.awsize, s_axi.awburst);
      r_wbeat    <= '0;
      r_werr     <= 1'b0;
    end else if (w_w_hs) begin
      r_aw_addr  <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
      r_wbeat    <= r_wbeat + 8'd1;
      r_werr     <= w_werr_acc;
      if (w_wlast_exp) r_bresp <= w_werr_acc ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // Storage write port: byte lanes gated by wstrb, erroring beats dropped; contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_w_hs && !w_wbeat_err) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) r_mem[w_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.awready = w_awready;
  assign s_axi.wready  = w_wready;
  assign s_axi.bvalid  = w_bvalid;
  assign s_axi.bresp   = r_bresp;
endmodule

// File: tb/tb_axi_full_mem_slave.sv
// Bench for axi_full_mem_slave: a table of write/read bursts checked against a reference memory
// model through a read-beat scoreboard, plus a hand-written reset-abort sequence.
module tb_axi_full_mem_slave;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = 1024;
  localparam int NV        = 21;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  axi_full_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  axi_full_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             wr;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0][63:0] wd;
    logic [3:0][7:0]  ws;
    logic             wlast_bad;
    logic [7:0]       rpat;
    logic [1:0]       exp_resp;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  vec_t        vecs [NV];
  rbeat_t      sb [$];
  logic [63:0] model_mem [MEM_WORDS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_berr(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return (burst == 2'b11) || (size > 3'd3) || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step, total, base;
    step  = 32'd1 << size;
    total = ({24'd0, len} + 32'd1) * step;
    base  = (a / total) * total;
    case (burst)
      2'b00:   return a;
      2'b10:   return base + ((a - base + step) % total);
      default: return a + step;
    endcase
  endfunction

  function automatic vec_t vw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                              input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                              input logic [63:0] d3, input logic [7:0] s1, input logic bad,
                              input logic [1:0] exp);
    vec_t v;
    v = '0;
    v.wr = 1'b1; v.addr = addr; v.len = len; v.size = 3'd3; v.burst = burst;
    v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2; v.wd[3] = d3;
    v.ws[0] = 8'hFF; v.ws[1] = s1; v.ws[2] = 8'hFF; v.ws[3] = 8'hFF;
    v.wlast_bad = bad; v.exp_resp = exp;
    return v;
  endfunction

  function automatic vec_t vr(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [7:0] rpat, input logic [1:0] exp);
    vec_t v;
    v = '0;
    v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.rpat = rpat; v.exp_resp = exp;
    return v;
  endfunction

  task automatic do_write(input int vi, input vec_t v, output logic [1:0] bresp);
    logic [31:0] a;
    logic        err, any_err;
    int          n;
    a = v.addr;
    any_err = v.wlast_bad;
    for (int i = 0; i <= int'(v.len); i++) begin
      err = m_berr(v.len, v.size, v.burst) || ((a >> 3) >= 32'd1024);
      any_err |= err;
      if (!err)
        for (int b = 0; b < 8; b++)
          if (v.ws[i][b]) model_mem[a >> 3][b*8 +: 8] = v.wd[i][b*8 +: 8];
      a = m_next(a, v.len, v.size, v.burst);
    end
    @(negedge clk);
    bus.awaddr = v.addr; bus.awlen = v.len; bus.awsize = v.size; bus.awburst = v.burst;
    bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("v%0d awready", vi), bus.awready, 1);
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk($sformatf("v%0d wready_lat", vi), bus.wready, 1);
    for (int i = 0; i <= int'(v.len); i++) begin
      bus.wdata  = v.wd[i];
      bus.wstrb  = v.ws[i];
      bus.wlast  = v.wlast_bad ? (i == 0) : (i == int'(v.len));
      bus.wvalid = 1'b1;
      n = 0;
      while (!bus.wready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    chk($sformatf("v%0d bvalid_lat", vi), bus.bvalid, 1);
    bus.bready = 1'b1;
    n = 0;
    while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
    bresp = bus.bresp;
    chk($sformatf("v%0d bresp_model", vi), bresp, any_err ? 2'b10 : 2'b00);
    @(negedge clk);
    bus.bready = 1'b0;
    chk($sformatf("v%0d awready_after", vi), bus.awready, 1);
    chk($sformatf("v%0d bvalid_after", vi), bus.bvalid, 0);
  endtask

  task automatic do_read(input int vi, input vec_t v, output logic [1:0] last_resp);
    logic [31:0] a;
    logic        err;
    rbeat_t      e;
    int          n, got;
    last_resp = 2'bxx;
    a = v.addr;
    for (int i = 0; i <= int'(v.len); i++) begin
      err = m_berr(v.len, v.size, v.burst) || ((a >> 3) >= 32'd1024);
      e.data = 64'd0;
      if (!err) e.data = model_mem[a >> 3];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (i == int'(v.len));
      sb.push_back(e);
      a = m_next(a, v.len, v.size, v.burst);
    end
    @(negedge clk);
    bus.araddr = v.addr; bus.arlen = v.len; bus.arsize = v.size; bus.arburst = v.burst;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("v%0d arready", vi), bus.arready, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk($sformatf("v%0d rvalid_lat", vi), bus.rvalid, 1);
    got = 0;
    n = 0;
    while (got <= int'(v.len) && n < 64) begin
      bus.rready = v.rpat[n % 8];
      if (bus.rvalid && sb.size() > 0) begin
        e = sb[0];
        chk($sformatf("v%0d b%0d rdata", vi, got), bus.rdata, e.data);
        chk($sformatf("v%0d b%0d rresp", vi, got), bus.rresp, e.resp);
        chk($sformatf("v%0d b%0d rlast", vi, got), bus.rlast, e.last);
        if (bus.rready) begin
          void'(sb.pop_front());
          last_resp = bus.rresp;
          got++;
        end
      end
      @(negedge clk);
      n++;
    end
    bus.rready = 1'b0;
    chk($sformatf("v%0d beats", vi), got, int'(v.len) + 1);
    chk($sformatf("v%0d arready_after", vi), bus.arready, 1);
    chk($sformatf("v%0d rvalid_after", vi), bus.rvalid, 0);
    sb.delete();
  endtask

  initial begin
    logic [1:0] resp;
    int         n;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst arready", bus.arready, 1);
    chk("rst awready", bus.awready, 1);
    chk("rst rvalid",  bus.rvalid, 0);
    chk("rst wready",  bus.wready, 0);
    chk("rst bvalid",  bus.bvalid, 0);
    chk("rst rlast",   bus.rlast, 0);
    chk("rst rresp",   bus.rresp, 0);
    chk("rst bresp",   bus.bresp, 0);
    chk("rst rdata",   bus.rdata, 0);
    rst = 1'b0;

    vecs[0]  = vw(32'h00, 3, 2'b01, 64'h1000, 64'h1001, 64'h1002, 64'h1003, 8'hFF, 0, 2'b00);
    vecs[1]  = vw(32'h20, 3, 2'b01, 64'h1004, 64'h1005, 64'h1006, 64'h1007, 8'hFF, 0, 2'b00);
    vecs[2]  = vr(32'h00, 3, 3'd3, 2'b01, 8'hFF, 2'b00);
    vecs[3]  = vr(32'h18, 3, 3'd3, 2'b10, 8'hFF, 2'b00);
    vecs[4]  = vw(32'h48, 0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 8'hFF, 0, 2'b00);
    vecs[5]  = vw(32'h40, 1, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 0, 0, 8'h0F, 0, 2'b00);
    vecs[6]  = vr(32'h40, 1, 3'd3, 2'b01, 8'hFF, 2'b00);
    vecs[7]  = vw(32'h40, 0, 2'b11, 64'hDEAD_BEEF, 0, 0, 0, 8'hFF, 0, 2'b10);
    vecs[8]  = vr(32'h40, 1, 3'd3, 2'b01, 8'hFF, 2'b00);
    vecs[9]  = vw(32'h2000, 0, 2'b01, 64'hBAD0, 0, 0, 0, 8'hFF, 0, 2'b10);
    vecs[10] = vw(32'h00, 2, 2'b10, 64'hBAD1, 64'hBAD2, 64'hBAD3, 0, 8'hFF, 0, 2'b10);
    vecs[11] = vr(32'h04, 3, 3'd2, 2'b01, 8'hFF, 2'b00);
    vecs[12] = vr(32'h00, 1, 3'd4, 2'b01, 8'hFF, 2'b10);
    vecs[13] = vw(32'h1FF8, 1, 2'b01, 64'h5A5A_5A5A_5A5A_5A5A, 64'h1, 0, 0, 8'hFF, 0, 2'b10);
    vecs[14] = vr(32'h1FF8, 1, 3'd3, 2'b01, 8'hFF, 2'b10);
    vecs[15] = vr(32'h08, 2, 3'd3, 2'b00, 8'h15, 2'b00);
    vecs[16] = vw(32'h68, 3, 2'b10, 64'hD0, 64'hD1, 64'hD2, 64'hD3, 8'hFF, 0, 2'b00);
    vecs[17] = vr(32'h60, 3, 3'd3, 2'b01, 8'hFF, 2'b00);
    vecs[18] = vw(32'h80, 1, 2'b01, 64'h77, 64'h88, 0, 0, 8'hFF, 1, 2'b10);
    vecs[19] = vr(32'h80, 1, 3'd3, 2'b01, 8'hFF, 2'b00);
    vecs[20] = vr(32'h08, 3, 3'd3, 2'b01, 8'hB6, 2'b00);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(i, vecs[i], resp);
        chk($sformatf("v%0d bresp", i), resp, vecs[i].exp_resp);
      end else begin
        do_read(i, vecs[i], resp);
        chk($sformatf("v%0d last rresp", i), resp, vecs[i].exp_resp);
      end
    end

    chk("mem word8",    dut.r_mem[8],    64'hAAAA_BBBB_CCCC_DDDD);
    chk("mem word9",    dut.r_mem[9],    64'hFFFF_FFFF_1111_1111);
    chk("mem word1023", dut.r_mem[1023], 64'h5A5A_5A5A_5A5A_5A5A);
    chk("mem word12",   dut.r_mem[12],   64'hD3);

    // Reset lands on the handshake of beat 2 of an 8-beat read.
    @(negedge clk);
    bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    n = 0;
    while (!bus.arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    @(negedge clk);
    chk("abort pre rvalid", bus.rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort rvalid",  bus.rvalid, 0);
    chk("abort arready", bus.arready, 1);
    chk("abort rlast",   bus.rlast, 0);
    chk("abort bvalid",  bus.bvalid, 0);
    rst = 1'b0;
    bus.rready = 1'b0;
    do_read(100, vr(32'h10, 1, 3'd3, 2'b01, 8'hFF, 2'b00), resp);
    chk("after abort rresp", resp, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
